// File: rtl/uart_pkg.sv
// Shared register map, control/status bit positions and TX state encoding
// for the memory-mapped UART transmitter.
package uart_pkg;

   localparam logic REG_DATA = 1'b0;
   localparam logic REG_CTRL = 1'b1;

   localparam int CTRL_CLR_OVF = 0;
   localparam int CTRL_TX_EN   = 1;
   localparam int CTRL_FLUSH   = 2;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_EN      = 4;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with show-ahead head output, occupancy count and a
// synchronous flush that takes priority over push/pop.
module io_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   // Fullness and emptiness are judged on the registered count, before any same-cycle pop.
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a byte FIFO, a
// four-state FSM serialises bytes LSB first, and a status word is readable.
module mio_uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 4
) (
   input  logic        clk,
   input  logic        RSTN,
   input  logic        io_we,
   input  logic        reg_sel,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        tx,
   output logic        tx_busy,
   output logic        irq
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   tx_state_t        state_reg, state_next;
   logic [BW-1:0]    baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_reg, tx_next;
   logic             ovf_reg;
   logic             tx_en_reg;

   logic             data_wr;
   logic             ctrl_wr;
   logic             fifo_pop;
   logic             fifo_flush;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             bit_end;
   logic             start_ok;
   logic [31:0]      status;
   logic             unused_wr_data;

   assign data_wr        = io_we && (reg_sel == REG_DATA);
   assign ctrl_wr        = io_we && (reg_sel == REG_CTRL);
   assign fifo_flush     = ctrl_wr && wr_data[CTRL_FLUSH];
   assign unused_wr_data = ^wr_data[31:8];

   io_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (RSTN),
      .push  (data_wr),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (wr_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         ovf_reg   <= 1'b0;
         tx_en_reg <= 1'b1;
      end else begin
         if (data_wr && fifo_full) begin
            ovf_reg <= 1'b1;
         end else if (ctrl_wr && wr_data[CTRL_CLR_OVF]) begin
            ovf_reg <= 1'b0;
         end
         if (ctrl_wr) begin
            tx_en_reg <= wr_data[CTRL_TX_EN];
         end
      end
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
      end
   end

   assign bit_end  = (baud_cnt_reg == BAUD_LAST);
   assign start_ok = tx_en_reg && !fifo_empty;

   // tx is registered, so every transition sets tx_next to the level of the bit it enters.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      fifo_pop      = 1'b0;
      if (state_reg != IDLE) begin
         baud_cnt_next = bit_end ? '0 : baud_cnt_reg + BW'(1);
      end
      case (state_reg)
         IDLE: begin
            baud_cnt_next = '0;
            if (start_ok) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_dout;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               bit_idx_next = '0;
               tx_next      = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  shift_next   = {1'b0, shift_reg[7:1]};
                  bit_idx_next = bit_idx_reg + 3'd1;
                  tx_next      = shift_reg[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (start_ok) begin
                  fifo_pop   = 1'b1;
                  shift_next = fifo_dout;
                  tx_next    = 1'b0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_comb begin
      status                          = '0;
      status[ST_EMPTY]                = fifo_empty;
      status[ST_FULL]                 = fifo_full;
      status[ST_BUSY]                 = tx_busy;
      status[ST_OVF]                  = ovf_reg;
      status[ST_EN]                   = tx_en_reg;
      status[ST_CNT_LSB +: CNT_W]     = fifo_count;
   end

   assign rd_data = (reg_sel == REG_CTRL) ? status : 32'h0;
   assign tx      = tx_reg;
   assign tx_busy = (state_reg != IDLE);
   assign irq     = tx_en_reg && fifo_empty;

endmodule

// File: tb/tb_mio_uart_tx.sv
// Bench for mio_uart_tx: expected bytes are queued when written and
// popped by a line monitor that decodes each 8N1 frame.
module tb_mio_uart_tx;

   localparam int BAUD  = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic        clk = 1'b0;
   logic        RSTN = 1'b0;
   logic        io_we = 1'b0;
   logic        reg_sel = 1'b0;
   logic [31:0] wr_data = 32'h0;
   logic [31:0] rd_data;
   logic        tx;
   logic        tx_busy;
   logic        irq;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          frames = 0;
   int          rst_epoch = 0;
   bit          in_frame = 1'b0;
   logic [7:0]  sb[$];
   int          starts[$];

   mio_uart_tx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CW)
   ) dut (
      .clk     (clk),
      .RSTN    (RSTN),
      .io_we   (io_we),
      .reg_sel (reg_sel),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .tx      (tx),
      .tx_busy (tx_busy),
      .irq     (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Called at a falling edge; returns at the falling edge after the write edge.
   task automatic wr(input logic sel, input logic [31:0] d);
      io_we   = 1'b1;
      reg_sel = sel;
      wr_data = d;
      @(posedge clk);
      @(negedge clk);
      io_we   = 1'b0;
      $display("write sel=%0d data=0x%08h at cycle %0d", sel, d, cyc);
   endtask

   task automatic rd_ctrl(output logic [31:0] v);
      reg_sel = 1'b1;
      #1;
      v = rd_data;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (k < budget && (tx_busy || in_frame || sb.size() != 0)) begin
         @(negedge clk);
         k++;
      end
      chk({"idle_", tag}, 32'(k < budget), 32'd1);
   endtask

   // Line monitor: samples each bit mid-way; a reset during the frame abandons it.
   initial begin
      logic tx_prev;
      tx_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (RSTN && tx_prev && !tx) begin : frame
            int         ep;
            logic [9:0] bits;
            bit         abort;
            bit         busy_ok;
            in_frame = 1'b1;
            starts.push_back(cyc);
            ep      = rst_epoch;
            abort   = 1'b0;
            busy_ok = 1'b1;
            bits    = '0;
            for (int i = 0; i < 10; i++) begin
               if (!abort) begin
                  repeat (i == 0 ? 2 : 4) @(negedge clk);
                  if (rst_epoch != ep || !RSTN) abort = 1'b1;
                  else begin
                     bits[i] = tx;
                     busy_ok = busy_ok && tx_busy;
                  end
               end
            end
            if (!abort) begin
               frames++;
               $display("frame %0d: byte 0x%02h start=%0d stop=%0d", frames, bits[8:1], bits[0], bits[9]);
               chk("start_bit", 32'(bits[0]), 32'd0);
               chk("stop_bit", 32'(bits[9]), 32'd1);
               chk("busy_in_frame", 32'(busy_ok), 32'd1);
               chk("frame_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) chk("frame_data", 32'(bits[8:1]), 32'(sb.pop_front()));
            end else begin
               $display("frame aborted by reset at cycle %0d", cyc);
            end
            in_frame = 1'b0;
         end
         tx_prev = tx;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int          s0;

      // Reset values, held while RSTN is low
      repeat (2) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_irq", 32'(irq), 32'd1);
      rd_ctrl(v);
      chk("rst_status", v, 32'h0000_0011);
      @(negedge clk);
      RSTN = 1'b1;
      @(negedge clk);
      reg_sel = 1'b0;
      #1;
      chk("rd_data_sel0", rd_data, 32'h0);

      // Single frame and one-cycle start latency
      sb.push_back(8'h55);
      wr(1'b0, 32'hFFFF_FF55);
      chk("lat_tx_pre", 32'(tx), 32'd1);
      rd_ctrl(v);
      chk("status_one_queued", v, 32'h0000_0110);
      @(negedge clk);
      chk("lat_tx_low", 32'(tx), 32'd0);
      chk("lat_busy", 32'(tx_busy), 32'd1);
      wait_idle("55", 60);

      // Back-to-back frames with no idle gap
      s0 = starts.size();
      sb.push_back(8'h41);
      sb.push_back(8'h42);
      wr(1'b0, 32'h41);
      wr(1'b0, 32'h42);
      rd_ctrl(v);
      chk("b2b_count1", v, 32'h0000_0114);
      chk("b2b_irq0", 32'(irq), 32'd0);
      repeat (39) @(negedge clk);
      rd_ctrl(v);
      chk("b2b_before_pop2", v, 32'h0000_0114);
      @(negedge clk);
      rd_ctrl(v);
      chk("b2b_after_pop2", v, 32'h0000_0015);
      chk("b2b_irq1", 32'(irq), 32'd1);
      wait_idle("b2b", 60);
      chk("b2b_gap", 32'(starts[s0 + 1] - starts[s0]), 32'd40);

      // Overflow with transmitter disabled
      wr(1'b1, 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) sb.push_back(8'(8'h10 + i));
         wr(1'b0, 32'(8'h10 + i));
      end
      rd_ctrl(v);
      chk("ovf_status", v, 32'h0000_040A);
      chk("ovf_tx_idle", 32'(tx), 32'd1);
      chk("ovf_irq", 32'(irq), 32'd0);
      wr(1'b1, 32'h3);
      rd_ctrl(v);
      chk("ovf_cleared", v, 32'h0000_0412);
      wait_idle("ovf", 200);
      rd_ctrl(v);
      chk("ovf_drained", v, 32'h0000_0011);

      // tx_en cleared mid-frame, then flush
      sb.push_back(8'hA5);
      wr(1'b0, 32'hA5);
      repeat (10) @(negedge clk);
      wr(1'b0, 32'h5A);
      wr(1'b1, 32'h0);
      wait_idle("a5", 60);
      repeat (20) @(negedge clk);
      rd_ctrl(v);
      chk("hold_status", v, 32'h0000_0100);
      chk("hold_tx", 32'(tx), 32'd1);
      wr(1'b1, 32'h4);
      rd_ctrl(v);
      chk("flush_status", v, 32'h0000_0001);
      s0 = starts.size();
      wr(1'b1, 32'h2);
      repeat (20) @(negedge clk);
      chk("no_frame_after_flush", 32'(starts.size()), 32'(s0));

      // Flush while a frame is on the line
      sb.push_back(8'h77);
      wr(1'b0, 32'h77);
      wr(1'b0, 32'h88);
      wr(1'b1, 32'h6);
      rd_ctrl(v);
      chk("flush_inflight_status", v, 32'h0000_0015);
      wait_idle("flush_inflight", 60);
      repeat (50) @(negedge clk);
      chk("flush_inflight_frames", 32'(starts.size()), 32'(s0 + 1));

      // Asynchronous reset during data bit 3
      s0 = starts.size();
      wr(1'b0, 32'h3C);
      repeat (18) @(negedge clk);
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      RSTN = 1'b0;
      rst_epoch++;
      #1;
      chk("async_rst_tx", 32'(tx), 32'd1);
      chk("async_rst_busy", 32'(tx_busy), 32'd0);
      rd_ctrl(v);
      chk("async_rst_status", v, 32'h0000_0011);
      @(negedge clk);
      RSTN = 1'b1;
      repeat (60) @(negedge clk);
      chk("no_spurious_frame", 32'(starts.size()), 32'(s0 + 1));
      chk("post_rst_tx", 32'(tx), 32'd1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("frame_total", 32'(frames), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
